// File: rtl/aes_inv_state_ctrl_if.sv
// Bus bundle for the decryption state controller: start/text, key-store read port,
// external inverse-round datapath, and the result handshake. AES_INV_ABORT_EN adds 'abort'.
interface aes_inv_state_ctrl_if #(
  parameter int KEY_AW = 4
);
  logic              ld;
  logic [127:0]      text_in;
  logic              kr_en;
  logic [KEY_AW-1:0] kr_addr;
  logic [127:0]      kr_data;
  logic [127:0]      st_out;
  logic              last_round;
  logic [127:0]      st_next;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [127:0]      text_out;
`ifdef AES_INV_ABORT_EN
  logic              abort;

  modport master (
    input  ld, text_in, kr_data, st_next, out_ready, abort,
    output kr_en, kr_addr, st_out, last_round, busy, out_valid, text_out
  );

  modport slave (
    output ld, text_in, kr_data, st_next, out_ready, abort,
    input  kr_en, kr_addr, st_out, last_round, busy, out_valid, text_out
  );
`else
  modport master (
    input  ld, text_in, kr_data, st_next, out_ready,
    output kr_en, kr_addr, st_out, last_round, busy, out_valid, text_out
  );

  modport slave (
    output ld, text_in, kr_data, st_next, out_ready,
    input  kr_en, kr_addr, st_out, last_round, busy, out_valid, text_out
  );
`endif
endinterface

// File: rtl/aes_inv_state_ctrl.sv
// Decryption state register and AddRoundKey sequencer (equivalent inverse cipher keys).
// Optional feature macro: AES_INV_ABORT_EN adds an abort input that cancels a block in LOAD/ROUND.
module aes_inv_state_ctrl #(
  parameter int NR     = 10,
  parameter int KEY_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  aes_inv_state_ctrl_if.master bus
);

  localparam int RW = $clog2(NR + 1);

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, OUT} fsm_t;

  fsm_t              fsm;
  logic [127:0]      text_r;
  logic [127:0]      st_reg;
  logic [RW-1:0]     rnd;
  logic              busy_r;
  logic              out_valid_r;
  logic              abort_req;
  logic              accept;
  logic              kr_en_c;
  logic [KEY_AW-1:0] kr_addr_c;

`ifdef AES_INV_ABORT_EN
  assign abort_req = bus.abort && ((fsm == LOAD) || (fsm == ROUND));
`else
  assign abort_req = 1'b0;
`endif

  // A new block may start from IDLE, or from OUT in the same cycle the result is taken.
  assign accept = bus.ld && ((fsm == IDLE) || ((fsm == OUT) && bus.out_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= IDLE;
      text_r      <= '0;
      st_reg      <= '0;
      rnd         <= '0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (abort_req) begin
      fsm         <= IDLE;
      st_reg      <= '0;
      rnd         <= '0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (accept) begin
            text_r <= bus.text_in;
            busy_r <= 1'b1;
            fsm    <= LOAD;
          end
        end
        LOAD: begin
          st_reg <= text_r ^ bus.kr_data;
          rnd    <= RW'(NR - 1);
          fsm    <= ROUND;
        end
        ROUND: begin
          st_reg <= bus.st_next ^ bus.kr_data;
          if (rnd == '0) begin
            out_valid_r <= 1'b1;
            fsm         <= OUT;
          end else begin
            rnd <= rnd - RW'(1);
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (accept) begin
              text_r <= bus.text_in;
              fsm    <= LOAD;
            end else begin
              busy_r <= 1'b0;
              fsm    <= IDLE;
            end
          end
        end
        default: begin
          fsm         <= IDLE;
          busy_r      <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Key reads run one cycle ahead of use so addresses NR..0 issue back to back.
  always_comb begin
    kr_en_c   = 1'b0;
    kr_addr_c = '0;
    if (!rst && !abort_req) begin
      case (fsm)
        IDLE, OUT: begin
          if (accept) begin
            kr_en_c   = 1'b1;
            kr_addr_c = KEY_AW'(NR);
          end
        end
        LOAD: begin
          kr_en_c   = 1'b1;
          kr_addr_c = KEY_AW'(NR - 1);
        end
        ROUND: begin
          if (rnd != '0) begin
            kr_en_c   = 1'b1;
            kr_addr_c = KEY_AW'(rnd - RW'(1));
          end
        end
        default: begin
          kr_en_c   = 1'b0;
          kr_addr_c = '0;
        end
      endcase
    end
  end

  assign bus.kr_en      = kr_en_c;
  assign bus.kr_addr    = kr_addr_c;
  assign bus.st_out     = (fsm == ROUND) ? st_reg : '0;
  assign bus.last_round = (fsm == ROUND) && (rnd == '0);
  assign bus.busy       = busy_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.text_out   = st_reg;

endmodule

// File: tb/tb_aes_inv_state_ctrl.sv
// Directed bench for aes_inv_state_ctrl: models the key store and the external inverse
// round logic, then checks the FIPS-197 C.1 decryption, sequencing, backpressure and reset.
module tb_aes_inv_state_ctrl;

  localparam int NR = 10;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT2 = 128'h0123456789abcdeffedcba9876543210;

  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;

  logic [7:0]   sbox    [256];
  logic [7:0]   invSbox [256];
  logic [127:0] dwMem   [16];

  aes_inv_state_ctrl_if #(.KEY_AW(4)) bus ();

  aes_inv_state_ctrl #(.NR(NR), .KEY_AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] invMixCol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] invMixAll(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = invMixCol(s[127-32*c -: 32]);
    return o;
  endfunction

  // InvSubBytes + InvShiftRows, then InvMixColumns except on the final round.
  function automatic logic [127:0] invRound(input logic [127:0] s, input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = invSbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[c*4+r] = b[((c - r + 4) % 4) * 4 + r];
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return last ? o : invMixAll(o);
  endfunction

  function automatic logic [127:0] refDecrypt(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ dwMem[NR];
    for (int r = NR - 1; r >= 0; r--) s = invRound(s, r == 0) ^ dwMem[r];
    return s;
  endfunction

  task automatic buildTables();
    logic [7:0]   inv;
    logic [7:0]   s;
    logic [7:0]   rc;
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [127:0] key;
    logic [127:0] rk;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv;
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x]  = s;
      invSbox[s] = 8'(x);
    end
    key = KEY;
    rc  = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) dwMem[i] = '0;
    for (int r = 0; r <= NR; r++) begin
      rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      dwMem[r] = (r == 0 || r == NR) ? rk : invMixAll(rk);
    end
  endtask

  // Key store with one cycle of read latency, and the external inverse round datapath.
  always @(posedge clk) begin
    if (bus.kr_en) bus.kr_data <= dwMem[bus.kr_addr];
  end

  assign bus.st_next = invRound(bus.st_out, bus.last_round);

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic ld, input logic [127:0] text, input logic ready);
    bus.ld        = ld;
    bus.text_in   = text;
    bus.out_ready = ready;
    #1;
  endtask

  // Issues ld in the current cycle and follows the block to its OUT cycle.
  task automatic runBlock(input logic [127:0] ct, input logic [127:0] pt,
                          input logic readyFirst, input int ldPulseAt);
    applyStimulus(1'b1, ct, readyFirst);
    checkOutput("issue_nr", 128'({bus.kr_en, bus.kr_addr}), 128'({1'b1, 4'(NR)}));
    for (int k = 1; k <= NR + 1; k++) begin
      step();
      applyStimulus(k == ldPulseAt, ~ct, 1'b0);
      if (k <= NR)
        checkOutput("kr_addr_seq", 128'({bus.kr_en, bus.kr_addr}), 128'({1'b1, 4'(NR - k)}));
      else
        checkOutput("kr_en_off", 128'({bus.kr_en, bus.kr_addr}), 128'(0));
      checkOutput("busy_run", 128'({bus.busy, bus.out_valid}), 128'(2'b10));
      checkOutput("last_round", 128'(bus.last_round), 128'(k == NR + 1));
    end
    step();
    applyStimulus(1'b0, ~ct, 1'b0);
    checkOutput("out_valid_done", 128'({bus.busy, bus.out_valid}), 128'(2'b11));
    checkOutput("text_out", bus.text_out, pt);
    checkOutput("st_out_out", bus.st_out, 128'(0));
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
`ifdef AES_INV_ABORT_EN
    bus.abort = 1'b0;
`endif
    applyStimulus(1'b1, CT, 1'b0);
    buildTables();
    repeat (3) step();

    // Reset state, with ld held high to show reset overrides it.
    checkOutput("rst_busy", 128'(bus.busy), 128'(0));
    checkOutput("rst_out_valid", 128'(bus.out_valid), 128'(0));
    checkOutput("rst_kr_en", 128'(bus.kr_en), 128'(0));
    checkOutput("rst_text_out", bus.text_out, 128'(0));
    checkOutput("rst_st_out", 128'({bus.st_out, bus.last_round}), 128'(0));
    applyStimulus(1'b0, CT, 1'b0);
    rst = 1'b0;
    step();
    checkOutput("idle_busy", 128'(bus.busy), 128'(0));

    // T2: FIPS-197 C.1 decryption.
    runBlock(CT, PT, 1'b0, -1);

    // T3: backpressure in OUT, with an ld pulse that must be ignored.
    for (int k = 1; k <= 5; k++) begin
      step();
      applyStimulus(k == 3, ~CT, 1'b0);
      checkOutput("t3_hold_valid", 128'({bus.busy, bus.out_valid, bus.kr_en}), 128'(3'b110));
      checkOutput("t3_hold_text", bus.text_out, PT);
    end
    applyStimulus(1'b0, 128'(0), 1'b1);
    step();
    applyStimulus(1'b0, 128'(0), 1'b0);
    checkOutput("t3_release", 128'({bus.busy, bus.out_valid}), 128'(0));
    checkOutput("t3_text_hold", bus.text_out, PT);

    // T4: ld pulse at rnd=7 is ignored. T5: back-to-back start from OUT.
    step();
    runBlock(CT, PT, 1'b0, 4);
    runBlock(CT2, refDecrypt(CT2), 1'b1, -1);
    applyStimulus(1'b0, 128'(0), 1'b1);
    step();
    applyStimulus(1'b0, 128'(0), 1'b0);
    checkOutput("t5_release", 128'({bus.busy, bus.out_valid}), 128'(0));

    // T1: two reset cycles while ROUND is at rnd=5.
    applyStimulus(1'b1, CT, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step();
      applyStimulus(1'b0, CT, 1'b0);
    end
    checkOutput("t1_at_rnd5", 128'({bus.kr_en, bus.kr_addr}), 128'(5'b10100));
    rst = 1'b1;
    step();
    checkOutput("t1_busy", 128'(bus.busy), 128'(0));
    checkOutput("t1_out_valid", 128'(bus.out_valid), 128'(0));
    checkOutput("t1_kr_en", 128'(bus.kr_en), 128'(0));
    checkOutput("t1_text_out", bus.text_out, 128'(0));
    step();
    rst = 1'b0;
    step();
    checkOutput("t1_idle", 128'({bus.busy, bus.out_valid, bus.kr_en}), 128'(0));

`ifdef AES_INV_ABORT_EN
    // T6: abort at rnd=4 together with an ignored ld.
    applyStimulus(1'b1, CT, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      step();
      applyStimulus(1'b0, CT, 1'b0);
    end
    bus.abort = 1'b1;
    applyStimulus(1'b1, ~CT, 1'b0);
    step();
    bus.abort = 1'b0;
    applyStimulus(1'b0, CT, 1'b0);
    checkOutput("t6_abort_idle", 128'({bus.busy, bus.out_valid, bus.kr_en}), 128'(0));
    checkOutput("t6_state_clr", bus.text_out, 128'(0));
    for (int k = 0; k < 14; k++) begin
      step();
      checkOutput("t6_no_valid", 128'({bus.busy, bus.out_valid}), 128'(0));
    end
`endif

    // Recovery after reset/abort.
    runBlock(CT, PT, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
